// File: rtl/instr_fetch_ctrl_pkg.sv
// ISA field positions, opcodes, bubble word and fetch-FSM encoding shared by
// the fetch controller and the executors.
package uc_isa_pkg;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int FLD1_HI = 11;
  localparam int FLD1_LO = 6;
  localparam int FLD2_HI = 5;
  localparam int FLD2_LO = 0;

  localparam logic [3:0] OPC_ALU  = 4'b0000;
  localparam logic [3:0] OPC_ALUI = 4'b0001;
  localparam logic [3:0] OPC_HALT = 4'b1111;

  localparam logic [15:0] BUBBLE_DEFAULT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH_ADDR = 3'd1,
    FETCH_RD   = 3'd2,
    LATCH      = 3'd3,
    DISPATCH   = 3'd4,
    BUBBLE     = 3'd5,
    HALTED     = 3'd6,
    FAULT      = 3'd7
  } fetch_state_t;
endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Memory/executor-side bus of the fetch controller.
// INSTR_COUNT_EN adds the retired-instruction counter.
interface instr_fetch_ctrl_if;
  logic        run;
  logic [15:0] memData;
  logic        memValid;
  logic        doneIn;
  logic        pcOutEN;
  logic        marLatch;
  logic        memRd;
  logic        irLatch;
  logic [15:0] instruction;
  logic        execValid;
  logic        halted;
  logic        fault;
`ifdef INSTR_COUNT_EN
  logic [15:0] instrCount;
`endif

  modport master (
    input  run, memData, memValid, doneIn,
    output pcOutEN, marLatch, memRd, irLatch, instruction, execValid, halted, fault
`ifdef INSTR_COUNT_EN
    , output instrCount
`endif
  );

  modport slave (
    output run, memData, memValid, doneIn,
    input  pcOutEN, marLatch, memRd, irLatch, instruction, execValid, halted, fault
`ifdef INSTR_COUNT_EN
    , input instrCount
`endif
  );
endinterface

// File: rtl/exec_watchdog.sv
// Cycle watchdog for the two wait states; flags a timeout on the last allowed
// cycle unless the awaited event shows up in that same cycle.
module exec_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic evt,
    output logic timeout
);
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          cnt <= '0;
        else if (clear)                   cnt <= '0;
        else if (enable && cnt != 8'hFF)  cnt <= cnt + 8'd1;
    end

    assign timeout = enable && !evt && (cnt == 8'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch/dispatch controller: fetch, latch IR, dispatch, one-cycle bubble.
// INSTR_COUNT_EN adds instrCount, bumped on every completed dispatch.
module instr_fetch_ctrl
  import uc_isa_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [3:0]  HALT_OPCODE    = OPC_HALT,
    parameter logic [15:0] BUBBLE_WORD    = BUBBLE_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_ctrl_if.master bus
);
    fetch_state_t state, nxt;
    logic [15:0]  ir;
    logic         wd_clear, wd_en, wd_evt, wd_timeout;

    assign wd_clear = (state == FETCH_ADDR) || (state == LATCH);
    assign wd_en    = (state == FETCH_RD) || (state == DISPATCH);
    assign wd_evt   = (state == FETCH_RD) ? bus.memValid : bus.doneIn;

    exec_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_en),
        .evt     (wd_evt),
        .timeout (wd_timeout)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:       if (bus.run) nxt = FETCH_ADDR;
            FETCH_ADDR: nxt = FETCH_RD;
            FETCH_RD:   if (bus.memValid) nxt = LATCH;
                        else if (wd_timeout) nxt = FAULT;
            LATCH:      nxt = (ir[OPC_HI:OPC_LO] == HALT_OPCODE) ? HALTED : DISPATCH;
            DISPATCH:   if (bus.doneIn) nxt = BUBBLE;
                        else if (wd_timeout) nxt = FAULT;
            BUBBLE:     nxt = bus.run ? FETCH_ADDR : IDLE;
            default:    nxt = state;
        endcase
    end

    // Outputs are registered from the next state so they track the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ir              <= BUBBLE_WORD;
            bus.instruction <= BUBBLE_WORD;
            bus.pcOutEN     <= 1'b0;
            bus.marLatch    <= 1'b0;
            bus.memRd       <= 1'b0;
            bus.irLatch     <= 1'b0;
            bus.execValid   <= 1'b0;
            bus.halted      <= 1'b0;
            bus.fault       <= 1'b0;
        end else begin
            state <= nxt;
            if (state == FETCH_RD && bus.memValid) ir <= bus.memData;
            bus.instruction <= (nxt == DISPATCH) ? ir : BUBBLE_WORD;
            bus.pcOutEN     <= (nxt == FETCH_ADDR);
            bus.marLatch    <= (nxt == FETCH_ADDR);
            bus.memRd       <= (nxt == FETCH_RD);
            bus.irLatch     <= (nxt == LATCH);
            bus.execValid   <= (nxt == DISPATCH);
            bus.halted      <= (nxt == HALTED);
            bus.fault       <= (nxt == FAULT);
        end
    end

`ifdef INSTR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              bus.instrCount <= '0;
        else if (state == DISPATCH && bus.doneIn) bus.instrCount <= bus.instrCount + 16'd1;
    end
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl; inputs change and outputs are sampled on
// the falling edge. Build with +define+INSTR_COUNT_EN to cover instrCount.
module tb_instr_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    instr_fetch_ctrl_if bus ();
    instr_fetch_ctrl #(.TIMEOUT_CYCLES(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic do_reset;
        bus.run = 0; bus.memValid = 0; bus.doneIn = 0; bus.memData = 16'h0;
        rst = 1; cyc; rst = 0; cyc;
    endtask

    // From IDLE: raise run, return with FETCH_ADDR visible.
    task automatic start;
        bus.run = 1; cyc;
    endtask

    // Starting with FETCH_ADDR visible, run one instruction through BUBBLE.
    task automatic run_instr(input logic [15:0] w, input int rd_dly, input int done_dly,
                             input bit run_after);
        chk("fa_pcOutEN", bus.pcOutEN, 1);
        chk("fa_marLatch", bus.marLatch, 1);
        cyc;
        for (int i = 0; i <= rd_dly; i++) begin
            chk("rd_memRd", bus.memRd, 1);
            if (i == rd_dly) begin bus.memValid = 1; bus.memData = w; end
            cyc;
        end
        bus.memValid = 0;
        chk("latch_irLatch", bus.irLatch, 1);
        chk("latch_instr", bus.instruction, 16'hFFFF);
        cyc;
        for (int i = 0; i <= done_dly; i++) begin
            chk("disp_instr", bus.instruction, w);
            chk("disp_execValid", bus.execValid, 1);
            if (i == done_dly) begin bus.doneIn = 1; bus.run = run_after; end
            cyc;
        end
        bus.doneIn = 0;
        chk("bubble_instr", bus.instruction, 16'hFFFF);
        chk("bubble_execValid", bus.execValid, 0);
        cyc;
    endtask

    // Starting with FETCH_ADDR visible, return with DISPATCH visible.
    task automatic to_dispatch(input logic [15:0] w);
        cyc;
        bus.memValid = 1; bus.memData = w; cyc;
        bus.memValid = 0; cyc;
    endtask

    task automatic test_reset;
        rst = 1; bus.run = 0; bus.memValid = 0; bus.doneIn = 0; bus.memData = 16'h0;
        cyc;
        chk("rst_instr", bus.instruction, 16'hFFFF);
        chk("rst_strobes", {bus.pcOutEN, bus.marLatch, bus.memRd, bus.irLatch, bus.execValid}, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_fault", bus.fault, 0);
`ifdef INSTR_COUNT_EN
        chk("rst_count", bus.instrCount, 0);
`endif
        rst = 0; cyc; cyc;
        chk("idle_pcOutEN", bus.pcOutEN, 0);
    endtask

    task automatic test_dispatch;
        int n;
        start;
        chk("t2_pcOutEN", bus.pcOutEN, 1);
        cyc;
        chk("t2_memRd0", bus.memRd, 1);
        cyc;
        chk("t2_memRd1", bus.memRd, 1);
        bus.memValid = 1; bus.memData = 16'h1042; cyc;
        bus.memValid = 0;
        chk("t2_irLatch", bus.irLatch, 1);
        cyc;
        n = 0;
        while (bus.instruction == 16'h1042 && n < 40) begin
            n++;
            if (n == 8) bus.doneIn = 1;
            cyc;
        end
        bus.doneIn = 0;
        chk("t2_disp_cycles", n, 8);
        chk("t2_bubble", bus.instruction, 16'hFFFF);
        chk("t2_bubble_pc", bus.pcOutEN, 0);
        cyc;
        run_instr(16'h2345, 0, 0, 0);
        cyc;
        chk("t2_idle_pc", bus.pcOutEN, 0);
        chk("t2_idle_rd", bus.memRd, 0);
    endtask

    task automatic test_reset_mid;
        start;
        to_dispatch(16'h1ABC);
        chk("t1_in_disp", bus.execValid, 1);
        bus.run = 0;
        rst = 1; #1;
        chk("t1_async_instr", bus.instruction, 16'hFFFF);
        chk("t1_async_exec", bus.execValid, 0);
        cyc; rst = 0; cyc;
        chk("t1_strobes", {bus.pcOutEN, bus.marLatch, bus.memRd, bus.irLatch, bus.execValid}, 0);
        chk("t1_flags", {bus.halted, bus.fault}, 0);
        chk("t1_instr", bus.instruction, 16'hFFFF);
        start;
        chk("t1_idle_then_fetch", bus.pcOutEN, 1);
        do_reset;
    endtask

    task automatic test_halt;
        bit saw_rd, saw_exec;
        start;
        cyc;
        bus.memValid = 1; bus.memData = 16'hF000; cyc;
        bus.memValid = 0;
        chk("t3_irLatch", bus.irLatch, 1);
        cyc;
        chk("t3_halted", bus.halted, 1);
        chk("t3_instr", bus.instruction, 16'hFFFF);
        saw_rd = 0; saw_exec = 0;
        for (int i = 0; i < 20; i++) begin
            saw_rd   |= bus.memRd | bus.pcOutEN;
            saw_exec |= bus.execValid;
            cyc;
        end
        chk("t3_no_fetch", saw_rd, 0);
        chk("t3_no_exec", saw_exec, 0);
        chk("t3_still_halted", bus.halted, 1);
        do_reset;
    endtask

    task automatic test_dispatch_timeout;
        int n;
        start;
        to_dispatch(16'h1001);
        n = 0;
        while (bus.execValid && n < 100) begin n++; cyc; end
        chk("t4_disp_cycles", n, 64);
        chk("t4_fault", bus.fault, 1);
        chk("t4_instr", bus.instruction, 16'hFFFF);
        do_reset;
        start;
        to_dispatch(16'h1002);
        for (int i = 1; i < 64; i++) cyc;
        chk("t4b_still_disp", bus.execValid, 1);
        bus.doneIn = 1; cyc;
        bus.doneIn = 0;
        chk("t4b_no_fault", bus.fault, 0);
        chk("t4b_bubble", {bus.execValid, bus.instruction}, {1'b0, 16'hFFFF});
        cyc;
        chk("t4b_next_fetch", bus.pcOutEN, 1);
        do_reset;
    endtask

    task automatic test_fetch_timeout;
        int n;
        start;
        cyc;
        n = 0;
        while (bus.memRd && n < 100) begin
            n++;
            bus.doneIn = (n % 3 == 0);
            cyc;
        end
        bus.doneIn = 0;
        chk("t5_rd_cycles", n, 64);
        chk("t5_fault", bus.fault, 1);
        chk("t5_no_exec", bus.execValid, 0);
        do_reset;
    endtask

    task automatic test_back_to_back;
        start;
        run_instr(16'h0011, 0, 0, 1);
        run_instr(16'h1022, 0, 2, 1);
        run_instr(16'h0033, 1, 0, 0);
`ifdef INSTR_COUNT_EN
        chk("t6_count", bus.instrCount, 3);
`endif
        chk("t6_idle_pc", bus.pcOutEN, 0);
        cyc;
        chk("t6_idle_rd", bus.memRd, 0);
        start;
        chk("t6_restart", bus.pcOutEN, 1);
        do_reset;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", chk_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_dispatch;
        test_reset_mid;
        test_halt;
        test_dispatch_timeout;
        test_fetch_timeout;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
